// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings, the
// transaction state enum and the alignment legality check.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } lsu_state_e;

  // True when addr_lo is naturally aligned for size; dword needs a 64-bit bus.
  function automatic logic access_legal(input logic [1:0] size,
                                        input logic [2:0] addr_lo,
                                        input logic       wide);
    logic ok;
    unique case (size)
      SZ_B:    ok = 1'b1;
      SZ_H:    ok = ~addr_lo[0];
      SZ_W:    ok = (addr_lo[1:0] == 2'b00);
      default: ok = wide && (addr_lo == 3'b000);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit: store mask/data placement and
// load extraction with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [1:0]                  size,
  input  logic [$clog2(DATA_W/8)-1:0] offset,
  input  logic                        sext,
  input  logic [DATA_W-1:0]           wdata,
  input  logic [DATA_W-1:0]           rdata,
  output logic [DATA_W/8-1:0]         wmask,
  output logic [DATA_W-1:0]           wdata_lane,
  output logic [DATA_W-1:0]           ld_data
);

  localparam int unsigned BW = DATA_W / 8;

  logic [BW-1:0]     base_mask;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] keep;
  logic              sbit;

  always_comb begin
    base_mask = '0;
    unique case (size)
      SZ_B:    base_mask[0]   = 1'b1;
      SZ_H:    base_mask[1:0] = 2'b11;
      SZ_W:    base_mask[3:0] = 4'hF;
      default: base_mask      = '1;
    endcase
  end

  assign wmask      = base_mask << offset;
  assign wdata_lane = wdata << {offset, 3'b000};
  assign shifted    = rdata >> {offset, 3'b000};

  // keep selects the loaded bits; everything above it is filled with the sign.
  // A full-width load keeps every bit, so the sign fill vanishes on its own.
  always_comb begin
    keep = '1;
    sbit = 1'b0;
    unique case (size)
      SZ_B: begin
        keep = DATA_W'(8'hFF);
        sbit = shifted[7];
      end
      SZ_H: begin
        keep = DATA_W'(16'hFFFF);
        sbit = shifted[15];
      end
      SZ_W: begin
        keep = DATA_W'(32'hFFFF_FFFF);
        sbit = shifted[31];
      end
      default: begin
        keep = '1;
        sbit = 1'b0;
      end
    endcase
  end

  assign ld_data = (shifted & keep) | ({DATA_W{sext & sbit}} & ~keep);

endmodule

// File: rtl/lsu_bus.sv
// Load/store unit with a clocked valid/ready memory port: one outstanding
// transaction, lane alignment, load extension, misalignment and timeout errors.
module lsu_bus
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic                mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned BW    = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(BW);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 2);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  lsu_state_e        state_q, state_d;
  logic              wen_q;
  logic              sext_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              accept;
  logic              legal;
  logic              timed_out;
  logic [BW-1:0]     lane_mask;
  logic [DATA_W-1:0] lane_wdata;
  logic [DATA_W-1:0] ld_data;

  assign accept    = (state_q == StIdle) && req_valid;
  assign legal     = access_legal(req_size, req_addr[2:0], DATA_W == 64);
  // Fires on the cycle the counter would reach TIMEOUT.
  assign timed_out = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  lsu_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .size       (size_q),
    .offset     (addr_q[OFF_W-1:0]),
    .sext       (sext_q),
    .wdata      (wdata_q),
    .rdata      (mem_rdata),
    .wmask      (lane_mask),
    .wdata_lane (lane_wdata),
    .ld_data    (ld_data)
  );

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = '0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          rdata_d = '0;
          err_d   = ~legal;
          state_d = legal ? StIssue : StResp;
        end
      end
      StIssue: begin
        if (mem_ready) begin
          if (wen_q) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = cnt_q + 1'b1;
          end
        end else if (timed_out) begin
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWait: begin
        if (mem_rvalid) begin
          rdata_d = ld_data;
          state_d = StResp;
        end else if (timed_out) begin
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      wen_q   <= 1'b0;
      sext_q  <= 1'b0;
      size_q  <= SZ_B;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wen_q   <= req_wen;
        sext_q  <= req_signed;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign mem_valid  = (state_q == StIssue);
  assign mem_wen    = mem_valid & wen_q;
  assign mem_addr   = mem_valid ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign mem_wdata  = mem_wen ? lane_wdata : '0;
  assign mem_wmask  = mem_wen ? lane_mask : '0;
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign resp_err   = resp_valid & err_q;

endmodule

// File: doc/lsu_bus.md
Name: lsu_bus

Overview:
Parametrised load/store unit that replaces the core's direct negedge DPI memory access with a clocked, handshaked memory port.
- Accepts one load/store request at a time from the decode/execute stage.
- Performs byte-lane alignment, write-mask generation, load extraction and sign/zero extension.
- Reports misaligned accesses and bus timeouts as errors.
- Sits between IDU/EXU and the memory bus; the memory-side DPI shim or SoC bus attaches to the mem_* ports.

Parameters:
ADDR_W, 32, address width in bits
DATA_W, 32, bus data width; 32 or 64 only
TIMEOUT, 255, cycles spent in ISSUE+WAIT before an error response; 0 disables the timeout

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous reset, active-low
req_valid  in  1  request valid
req_ready  out  1  unit can accept a request
req_wen  in  1  1 = store, 0 = load
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword (dword legal only when DATA_W = 64)
req_signed  in  1  sign-extend load result
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data, LSB-justified
resp_valid  out  1  response valid
resp_ready  in  1  consumer accepts response
resp_rdata  out  DATA_W  extended load data; 0 for stores and errors
resp_err  out  1  misaligned, illegal size, or timeout
mem_valid  out  1  bus request valid
mem_ready  in  1  bus accepts request
mem_wen  out  1  bus write
mem_addr  out  ADDR_W  address aligned down to DATA_W/8
mem_wdata  out  DATA_W  store data shifted to its byte lane
mem_wmask  out  DATA_W/8  byte-enable mask
mem_rvalid  in  1  read data valid
mem_rdata  in  DATA_W  full-width read data

Behaviour:
Reset (rst = 0 at posedge):
- state = IDLE; counter cleared; all outputs 0 except req_ready = 1.
- Reset mid-transaction abandons the transaction. No response is issued. A late mem_rvalid after reset is ignored in IDLE.

States: IDLE, ISSUE, WAIT, RESP. req_ready = (state == IDLE). One transaction is outstanding at most.
- IDLE: on req_valid, register the request. Illegal request (addr not aligned to its size, or size = 3 with DATA_W = 32) -> RESP with err = 1, and no bus activity. Otherwise -> ISSUE.
- ISSUE: mem_valid = 1, and mem_* stay stable until mem_ready. On mem_ready, a store goes to RESP and a load goes to WAIT.
- WAIT: on mem_rvalid, extract bytes at the address offset, extend per req_signed, and go to RESP. mem_rvalid outside WAIT is ignored.
- RESP: resp_valid = 1 with rdata/err held stable until resp_ready, then -> IDLE. A new request is accepted no earlier than the cycle after the response handshake.
- Timeout: the counter increments each cycle in ISSUE or WAIT. When it reaches TIMEOUT (TIMEOUT > 0), go to RESP with err = 1 and drop mem_valid. The counter clears on leaving ISSUE/WAIT.

Latency (zero-wait bus, resp_ready = 1):
- Store: accepted at cycle 0, mem_valid at cycle 1, resp_valid at cycle 2.
- Load: accepted at cycle 0, mem_valid at cycle 1, rvalid at cycle 2, resp_valid at cycle 3.

Width rules:
- Lane offset = addr[log2(DATA_W/8)-1:0].
- wmask = ((1 << (1 << size)) - 1) << offset.
- wdata = req_wdata << (8 * offset).
- Load data = mem_rdata >> (8 * offset), truncated to 8 << size bits, then sign- or zero-extended to DATA_W.
- A load of the full bus width ignores req_signed.

Decomposition:
- Package lsu_pkg: size encodings (SZ_B = 0, SZ_H = 1, SZ_W = 2, SZ_D = 3), the state enum, and a function that checks alignment legality.
- Sub-module lsu_align: combinational. Computes wmask/wdata from size/offset/wdata, and load extraction/extension from size/offset/signed/rdata. It is instantiated once in lsu_bus.

Test Plan:
1. DATA_W = 32, store byte 0xAB to 0x8000_0003 -> mem_addr 0x8000_0000, wmask 4'b1000, wdata 0xAB00_0000; resp_valid at cycle 2, err = 0.
2. DATA_W = 32, signed half load from 0x8000_0002, mem_rdata 0x8001_1234 -> resp_rdata 0xFFFF_8001. Same load unsigned -> 0x0000_8001.
3. Word load from 0x8000_0006 -> resp_err = 1 one cycle after acceptance, mem_valid never asserted.
4. TIMEOUT = 4, mem_ready held at 0 -> mem_valid high for 4 cycles, then resp_err = 1 and mem_valid = 0.
5. DATA_W = 64, dword store to 0x10, then signed word load from 0x14 with mem_rdata 0xFFFF_FFFE_0000_0001 -> wmask 8'hFF; rdata 0xFFFF_FFFF_FFFF_FFFE.
6. rst driven low while in WAIT, then mem_rvalid pulses after reset -> no resp_valid, and req_ready = 1 on the cycle after reset releases.
